qspi_host: RTL

- Quad-SPI host (initiator) for the chess core's nibble-wide serial port.
- Drives sck, cs_n and the 4-bit host→device data lines; samples the 4-bit device→host lines.
- Used in the FPGA/bench harness, and by any on-board controller that issues commands and reads results.
- Byte-stream user side: bytes to send are consumed from a valid/ready stream; received bytes are emitted as single-cycle pulses.

---
 rtl/qspi_host.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_host.sv
// Quad-SPI host: byte stream in, nibble-serial mode-0 bus out, received bytes as strobes.
// Outputs are registered except tx_ready, which is combinational on tx_valid at a byte boundary.
module qspi_host #(
  parameter int DIV   = 2,
  parameter int DUMMY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_len,
  input  logic [7:0] rx_len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       qspi_sck,
  output logic       qspi_cs_n,
  output logic [3:0] qspi_dout,
  input  logic [3:0] qspi_din
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_TXW, S_TX, S_DUMMY, S_RX, S_HOLD, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dum_q, dum_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rx_valid_q, rx_valid_d;
  logic          nib_q, nib_d;
  logic [3:0]    dout_q, dout_d;
  logic [3:0]    rx_hi_q, rx_hi_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [7:0]    tx_left_q, tx_left_d;
  logic [7:0]    rx_left_q, rx_left_d;
  logic [7:0]    sh_q, sh_d;
  logic          half_end;
  logic          boundary;
  logic          to_post_tx;

  assign half_end = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = half_end ? '0 : cnt_q + CW'(1);
    dum_d      = dum_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    nib_d      = nib_q;
    dout_d     = dout_q;
    rx_hi_d    = rx_hi_q;
    rx_data_d  = rx_data_q;
    tx_left_d  = tx_left_q;
    rx_left_d  = rx_left_q;
    sh_d       = sh_q;
    tx_ready   = 1'b0;
    boundary   = 1'b0;
    to_post_tx = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_left_d = tx_len;
          rx_left_d = rx_len;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (half_end) begin
          if (tx_left_q != 8'd0) boundary = 1'b1;
          else                   to_post_tx = 1'b1;
        end
      end
      S_TXW: begin
        boundary = 1'b1;
      end
      S_TX: begin
        if (half_end) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (!nib_q) begin
            sck_d  = 1'b0;
            nib_d  = 1'b1;
            dout_d = sh_q[3:0];
          end else if (tx_left_q != 8'd0) begin
            boundary = 1'b1;
          end else begin
            to_post_tx = 1'b1;
          end
        end
      end
      S_DUMMY: begin
        if (half_end) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            dum_d = dum_q - CW'(1);
            if (dum_q == CW'(1)) begin
              state_d = S_RX;
              nib_d   = 1'b0;
            end
          end
        end
      end
      S_RX: begin
        if (half_end) begin
          if (!sck_q) begin
            // sample on the same edge that raises sck
            sck_d = 1'b1;
            if (!nib_q) begin
              rx_hi_d = qspi_din;
            end else begin
              rx_data_d  = {rx_hi_q, qspi_din};
              rx_valid_d = 1'b1;
            end
          end else begin
            sck_d = 1'b0;
            if (!nib_q) begin
              nib_d = 1'b1;
            end else begin
              nib_d     = 1'b0;
              rx_left_d = rx_left_q - 8'd1;
              if (rx_left_q == 8'd1) state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (half_end) begin
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (half_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte boundary: take a byte if offered, otherwise park with sck low until one arrives.
    if (boundary) begin
      tx_ready = tx_valid;
      sck_d    = 1'b0;
      cnt_d    = '0;
      if (tx_valid) begin
        state_d   = S_TX;
        sh_d      = tx_data;
        dout_d    = tx_data[7:4];
        nib_d     = 1'b0;
        tx_left_d = tx_left_q - 8'd1;
      end else begin
        state_d = S_TXW;
      end
    end

    if (to_post_tx) begin
      sck_d  = 1'b0;
      cnt_d  = '0;
      dout_d = 4'd0;
      if (rx_left_q != 8'd0) begin
        if (DUMMY > 0) begin
          state_d = S_DUMMY;
          dum_d   = CW'(DUMMY);
        end else begin
          state_d = S_RX;
          nib_d   = 1'b0;
        end
      end else begin
        state_d = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dum_q      <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      nib_q      <= 1'b0;
      dout_q     <= 4'd0;
      rx_hi_q    <= 4'd0;
      rx_data_q  <= 8'd0;
      tx_left_q  <= 8'd0;
      rx_left_q  <= 8'd0;
      sh_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dum_q      <= dum_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      nib_q      <= nib_d;
      dout_q     <= dout_d;
      rx_hi_q    <= rx_hi_d;
      rx_data_q  <= rx_data_d;
      tx_left_q  <= tx_left_d;
      rx_left_q  <= rx_left_d;
      sh_q       <= sh_d;
    end
  end

  assign qspi_sck  = sck_q;
  assign qspi_cs_n = cs_n_q;
  assign qspi_dout = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;

endmodule
